// File: rtl/paula_floppy_pkg.sv
// Shared types and constants for the Paula floppy read path.
package paula_floppy_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        XFER      = 2'd2
    } state_e;

    localparam logic [15:0] DSKSYNC_DEFAULT = 16'h4489;
    localparam int          LEN_W           = 14;

endpackage

// File: rtl/paula_floppy_deserializer_if.sv
// FIFO write port between the deserializer (master) and the floppy FIFO (slave).
interface paula_floppy_deserializer_if;

    logic        fifo_wr;
    logic [15:0] fifo_data;
    logic        fifo_full;

    modport master (
        output fifo_wr,
        output fifo_data,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr,
        input  fifo_data,
        output fifo_full
    );

endinterface

// File: rtl/paula_floppy_syncdet.sv
// MFM shift register, DSKSYNC compare and the WORDEQUAL hold timer.
module paula_floppy_syncdet
    import paula_floppy_pkg::*;
#(
    parameter int WORDEQUAL_CYCLES = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        bit_in_i,
    input  logic        bit_strobe_i,
    input  logic [15:0] sync_word_i,
    output logic [15:0] sr_next_o,
    output logic        match_o,
    output logic        word_equal_o
);

    localparam int WEQ_W = $clog2(WORDEQUAL_CYCLES + 1);

    logic [15:0]      sr_q;
    logic [15:0]      sr_d;
    logic [WEQ_W-1:0] weq_cnt_q;
    logic [WEQ_W-1:0] weq_cnt_d;
    logic             shift;
    logic             match;

    // The match looks at the post-shift value so it fires on the edge that
    // clocks in the last sync bit.
    always_comb begin
        shift     = clk7_en & bit_strobe_i;
        sr_d      = shift ? {sr_q[14:0], bit_in_i} : sr_q;
        match     = shift && (sr_d == sync_word_i);
        weq_cnt_d = weq_cnt_q;
        if (match) begin
            weq_cnt_d = WEQ_W'(WORDEQUAL_CYCLES);
        end else if (clk7_en && (weq_cnt_q != '0)) begin
            weq_cnt_d = weq_cnt_q - WEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q      <= '0;
            weq_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            weq_cnt_q <= weq_cnt_d;
        end
    end

    assign sr_next_o    = sr_d;
    assign match_o      = match;
    assign word_equal_o = (weq_cnt_q != '0);

endmodule

// File: rtl/paula_floppy_deserializer.sv
// Paula floppy read deserializer: MFM bits to FIFO words, DSKSYNC alignment,
// DSKLEN word counting, sync/block interrupts and the DSKBYTR byte path.
module paula_floppy_deserializer
    import paula_floppy_pkg::*;
#(
    parameter int WORDEQUAL_CYCLES = 14,
    parameter int LEN_W            = paula_floppy_pkg::LEN_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk7_en,
    input  logic                        bit_in_i,
    input  logic                        bit_strobe_i,
    input  logic [15:0]                 sync_word_i,
    input  logic                        wordsync_en_i,
    input  logic                        dma_en_i,
    input  logic                        start_i,
    input  logic [LEN_W-1:0]            len_i,
    paula_floppy_deserializer_if.master fifo_if,
    output logic                        syncint_o,
    output logic                        blkint_o,
    output logic                        overrun_o,
    output logic                        busy_o,
    output logic [7:0]                  byte_data_o,
    output logic                        byte_ready_o,
    input  logic                        byte_ack_i,
    output logic                        word_equal_o
);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       bitcnt_q;
    logic [3:0]       bitcnt_d;
    logic [2:0]       bytecnt_q;
    logic [2:0]       bytecnt_d;
    logic [LEN_W-1:0] wcnt_q;
    logic [LEN_W-1:0] wcnt_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             fifo_wr_q;
    logic             fifo_wr_d;
    logic [15:0]      fifo_data_q;
    logic [15:0]      fifo_data_d;
    logic             syncint_q;
    logic             syncint_d;
    logic             blkint_q;
    logic             blkint_d;
    logic [7:0]       byte_data_q;
    logic [7:0]       byte_data_d;
    logic             byte_ready_q;
    logic             byte_ready_d;

    logic [15:0]      sr_next;
    logic             match;
    logic             shift;
    logic             realign;
    logic             word_done;
    logic             byte_done;
    logic             start_ok;

    paula_floppy_syncdet #(
        .WORDEQUAL_CYCLES (WORDEQUAL_CYCLES)
    ) u_syncdet (
        .clk          (clk),
        .reset        (reset),
        .clk7_en      (clk7_en),
        .bit_in_i     (bit_in_i),
        .bit_strobe_i (bit_strobe_i),
        .sync_word_i  (sync_word_i),
        .sr_next_o    (sr_next),
        .match_o      (match),
        .word_equal_o (word_equal_o)
    );

    // A realigning match closes the current word/byte exactly like a wrap.
    always_comb begin
        shift     = clk7_en & bit_strobe_i;
        realign   = match & wordsync_en_i;
        word_done = shift & (realign | (bitcnt_q == 4'd15));
        byte_done = shift & (realign | (bytecnt_q == 3'd7));
        start_ok  = start_i & dma_en_i & (len_i != '0);
    end

    always_comb begin
        bitcnt_d     = bitcnt_q;
        bytecnt_d    = bytecnt_q;
        byte_data_d  = byte_data_q;
        byte_ready_d = byte_ready_q;
        if (shift) begin
            bitcnt_d  = realign ? 4'd0 : bitcnt_q + 4'd1;
            bytecnt_d = realign ? 3'd0 : bytecnt_q + 3'd1;
        end
        if ((state_q == IDLE) && start_ok) begin
            bitcnt_d = 4'd0;
        end
        // A fresh byte beats a simultaneous DSKBYTR read.
        if (byte_done) begin
            byte_data_d  = sr_next[7:0];
            byte_ready_d = 1'b1;
        end else if (byte_ack_i) begin
            byte_ready_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        overrun_d   = overrun_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = 16'h0000;
        blkint_d    = 1'b0;
        syncint_d   = match;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    wcnt_d    = len_i;
                    overrun_d = 1'b0;
                    state_d   = wordsync_en_i ? WAIT_SYNC : XFER;
                end
            end
            WAIT_SYNC: begin
                if (!dma_en_i) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!dma_en_i) begin
                    state_d = IDLE;
                end else if (word_done) begin
                    if (fifo_if.fifo_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        fifo_wr_d   = 1'b1;
                        fifo_data_d = sr_next;
                    end
                    wcnt_d = wcnt_q - LEN_W'(1);
                    if (wcnt_q == LEN_W'(1)) begin
                        blkint_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            bytecnt_q    <= '0;
            wcnt_q       <= '0;
            overrun_q    <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
            syncint_q    <= 1'b0;
            blkint_q     <= 1'b0;
            byte_data_q  <= '0;
            byte_ready_q <= 1'b0;
        end else if (clk7_en) begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            bytecnt_q    <= bytecnt_d;
            wcnt_q       <= wcnt_d;
            overrun_q    <= overrun_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            syncint_q    <= syncint_d;
            blkint_q     <= blkint_d;
            byte_data_q  <= byte_data_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign fifo_if.fifo_wr   = fifo_wr_q;
    assign fifo_if.fifo_data = fifo_data_q;
    assign syncint_o         = syncint_q;
    assign blkint_o          = blkint_q;
    assign overrun_o         = overrun_q;
    assign busy_o            = (state_q != IDLE);
    assign byte_data_o       = byte_data_q;
    assign byte_ready_o      = byte_ready_q;

endmodule

// File: tb/tb_paula_floppy_deserializer.sv
// Bench for paula_floppy_deserializer: directed scenarios plus random traffic,
// checked every cycle against a word/byte-level reference model.
module tb_paula_floppy_deserializer;

    localparam int WEQ     = 14;
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_XFER  = 2;

    logic        clk;
    logic        reset;
    logic        clk7_en;
    logic        bit_in;
    logic        bit_strobe;
    logic [15:0] sync_word;
    logic        wordsync_en;
    logic        dma_en;
    logic        start;
    logic [13:0] len;
    logic        syncint;
    logic        blkint;
    logic        overrun;
    logic        busy;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        byte_ack;
    logic        word_equal;

    paula_floppy_deserializer_if fif ();

    paula_floppy_deserializer dut (
        .clk           (clk),
        .reset         (reset),
        .clk7_en       (clk7_en),
        .bit_in_i      (bit_in),
        .bit_strobe_i  (bit_strobe),
        .sync_word_i   (sync_word),
        .wordsync_en_i (wordsync_en),
        .dma_en_i      (dma_en),
        .start_i       (start),
        .len_i         (len),
        .fifo_if       (fif),
        .syncint_o     (syncint),
        .blkint_o      (blkint),
        .overrun_o     (overrun),
        .busy_o        (busy),
        .byte_data_o   (byte_data),
        .byte_ready_o  (byte_ready),
        .byte_ack_i    (byte_ack),
        .word_equal_o  (word_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept in word/byte terms.
    logic [15:0] m_sr;
    int          m_bits_w;
    int          m_bits_b;
    int          m_mode;
    int          m_left;
    int          m_weq;
    logic        m_ovr;
    logic        m_wr;
    logic [15:0] m_data;
    logic        m_sync;
    logic        m_blk;
    logic [7:0]  m_byte;
    logic        m_rdy;

    // Observed-event log for the hand-computed expectations.
    logic [15:0] wlog[$];
    int          n_sync = 0;
    int          n_blk  = 0;
    int          n_bw   = 0;
    int          n_weq  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [15:0] nsr;
        logic        hit;
        logic        al;
        logic        done;
        logic        accept;
        if (reset) begin
            m_sr = '0; m_bits_w = 0; m_bits_b = 0; m_mode = M_IDLE; m_left = 0;
            m_weq = 0; m_ovr = 0; m_wr = 0; m_data = '0; m_sync = 0; m_blk = 0;
            m_byte = '0; m_rdy = 0;
            return;
        end
        if (!clk7_en) return;
        m_wr = 0; m_data = '0; m_sync = 0; m_blk = 0;
        nsr  = bit_strobe ? {m_sr[14:0], bit_in} : m_sr;
        hit  = bit_strobe && (nsr == sync_word);
        al   = hit && wordsync_en;
        m_sync = hit;
        if (hit) m_weq = WEQ;
        else if (m_weq > 0) m_weq--;
        if (bit_strobe && (al || m_bits_b == 7)) begin
            m_byte = nsr[7:0];
            m_rdy  = 1;
        end else if (byte_ack) begin
            m_rdy = 0;
        end
        if (bit_strobe) m_bits_b = al ? 0 : (m_bits_b + 1) % 8;
        done   = bit_strobe && (al || m_bits_w == 15);
        accept = (m_mode == M_IDLE) && start && dma_en && (len != 0);
        if (accept) m_bits_w = 0;
        else if (bit_strobe) m_bits_w = al ? 0 : (m_bits_w + 1) % 16;
        if (m_mode == M_IDLE) begin
            if (accept) begin
                m_left = int'(len);
                m_ovr  = 0;
                m_mode = wordsync_en ? M_WAIT : M_XFER;
            end
        end else if (!dma_en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_WAIT) begin
            if (hit) m_mode = M_XFER;
        end else if (done) begin
            if (fif.fifo_full) m_ovr = 1;
            else begin
                m_wr   = 1;
                m_data = nsr;
            end
            m_left--;
            if (m_left == 0) begin
                m_blk  = 1;
                m_mode = M_IDLE;
            end
        end
        m_sr = nsr;
    endtask

    // One clock: model advances on the edge, DUT is compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("fifo_wr",    32'(fif.fifo_wr),   32'(m_wr));
        chk("fifo_data",  32'(fif.fifo_data), 32'(m_data));
        chk("syncint",    32'(syncint),       32'(m_sync));
        chk("blkint",     32'(blkint),        32'(m_blk));
        chk("overrun",    32'(overrun),       32'(m_ovr));
        chk("busy",       32'(busy),          32'(m_mode != M_IDLE));
        chk("byte_data",  32'(byte_data),     32'(m_byte));
        chk("byte_ready", 32'(byte_ready),    32'(m_rdy));
        chk("word_equal", 32'(word_equal),    32'(m_weq > 0));
        if (clk7_en && !reset) begin
            if (fif.fifo_wr) wlog.push_back(fif.fifo_data);
            if (syncint) n_sync++;
            if (blkint) n_blk++;
            if (blkint && fif.fifo_wr) n_bw++;
            if (word_equal) n_weq++;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        bit_in = b; bit_strobe = 1'b1;
        tick();
        bit_strobe = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_start(input int l);
        start = 1'b1; len = 14'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fifo_wr"},    32'(fif.fifo_wr),   32'h0);
        chk({tag, "_fifo_data"},  32'(fif.fifo_data), 32'h0);
        chk({tag, "_syncint"},    32'(syncint),       32'h0);
        chk({tag, "_blkint"},     32'(blkint),        32'h0);
        chk({tag, "_overrun"},    32'(overrun),       32'h0);
        chk({tag, "_busy"},       32'(busy),          32'h0);
        chk({tag, "_byte_data"},  32'(byte_data),     32'h0);
        chk({tag, "_byte_ready"}, 32'(byte_ready),    32'h0);
        chk({tag, "_word_equal"}, 32'(word_equal),    32'h0);
    endtask

    initial begin
        int          w0;
        int          s0;
        int          b0;
        int          bw0;
        int          q0;
        logic        qbits[$];
        logic [15:0] rw;

        reset = 1'b1; clk7_en = 1'b1; bit_in = 1'b0; bit_strobe = 1'b0;
        sync_word = 16'h4489; wordsync_en = 1'b1; dma_en = 1'b1; start = 1'b0;
        len = '0; byte_ack = 1'b0; fif.fifo_full = 1'b0;
        cyc(2);
        chk_all_zero("reset");
        reset = 1'b0;

        // Sync-gated two-word read.
        w0 = wlog.size(); s0 = n_sync; b0 = n_blk; bw0 = n_bw;
        do_start(2);
        send_bits(16'h4489, 16);
        send_bits(16'hAAAA, 16);
        send_bits(16'h5555, 16);
        cyc(4);
        chk("t1_writes", 32'(wlog.size() - w0), 32'd2);
        if (wlog.size() >= w0 + 2) begin
            chk("t1_word0", 32'(wlog[w0]),     32'h0000AAAA);
            chk("t1_word1", 32'(wlog[w0 + 1]), 32'h00005555);
        end
        chk("t1_syncint",   32'(n_sync - s0), 32'd1);
        chk("t1_blkint",    32'(n_blk - b0),  32'd1);
        chk("t1_blk_on_wr", 32'(n_bw - bw0),  32'd1);
        chk("t1_idle",      32'(busy),        32'd0);

        // Unsynchronised single word.
        wordsync_en = 1'b0;
        w0 = wlog.size(); b0 = n_blk;
        do_start(1);
        send_bits(16'h1234, 16);
        cyc(2);
        chk("t2_writes", 32'(wlog.size() - w0), 32'd1);
        if (wlog.size() >= w0 + 1) chk("t2_word0", 32'(wlog[w0]), 32'h00001234);
        chk("t2_blkint", 32'(n_blk - b0), 32'd1);

        // Byte realignment and WORDEQUAL length.
        reset = 1'b1; tick(); reset = 1'b0;
        wordsync_en = 1'b1; q0 = n_weq;
        send_bits(16'h0005, 3);
        send_bits(16'h4489, 16);
        send_bits(16'h0000, 8);
        chk("t3_byte00",  32'(byte_data),  32'h00);
        chk("t3_ready00", 32'(byte_ready), 32'd1);
        byte_ack = 1'b1; tick(); byte_ack = 1'b0;
        chk("t3_acked",   32'(byte_ready), 32'd0);
        send_bits(16'h00FF, 8);
        chk("t3_byteFF",  32'(byte_data),  32'hFF);
        chk("t3_readyFF", 32'(byte_ready), 32'd1);
        byte_ack = 1'b1; tick(); byte_ack = 1'b0;
        chk("t3_weq_len", 32'(n_weq - q0), 32'd14);

        // FIFO full during the middle word.
        wordsync_en = 1'b0;
        w0 = wlog.size(); b0 = n_blk;
        do_start(3);
        send_bits(16'h0F0F, 16);
        fif.fifo_full = 1'b1;
        send_bits(16'hBEEF, 16);
        fif.fifo_full = 1'b0;
        send_bits(16'h1357, 16);
        cyc(2);
        chk("t4_writes", 32'(wlog.size() - w0), 32'd2);
        if (wlog.size() >= w0 + 2) begin
            chk("t4_word0", 32'(wlog[w0]),     32'h00000F0F);
            chk("t4_word1", 32'(wlog[w0 + 1]), 32'h00001357);
        end
        chk("t4_overrun", 32'(overrun),     32'd1);
        chk("t4_blkint",  32'(n_blk - b0),  32'd1);

        // Zero-length start, then DMA drop mid-transfer.
        b0 = n_blk;
        do_start(0);
        chk("t5_len0_busy", 32'(busy), 32'd0);
        cyc(2);
        w0 = wlog.size();
        do_start(4);
        send_bits(16'h6A6A, 16);
        dma_en = 1'b0; tick();
        chk("t5_abort_busy", 32'(busy), 32'd0);
        send_bits(16'h7B7B, 16);
        dma_en = 1'b1;
        cyc(2);
        chk("t5_writes", 32'(wlog.size() - w0), 32'd1);
        chk("t5_no_blk", 32'(n_blk - b0),       32'd0);

        // Reset mid-transfer, then a normal transfer.
        do_start(2);
        send_bits(16'h03FF, 10);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all_zero("t6");
        w0 = wlog.size(); b0 = n_blk;
        do_start(1);
        send_bits(16'hC3A5, 16);
        cyc(2);
        chk("t6_writes", 32'(wlog.size() - w0), 32'd1);
        if (wlog.size() >= w0 + 1) chk("t6_word0", 32'(wlog[w0]), 32'h0000C3A5);
        chk("t6_blkint", 32'(n_blk - b0), 32'd1);

        // Random traffic with embedded sync words and back-to-back strobes.
        sync_word = paula_floppy_pkg::DSKSYNC_DEFAULT;
        for (int c = 0; c < 6000; c++) begin
            if (c == 3000) sync_word = 16'($urandom);
            if (qbits.size() == 0) begin
                rw = ($urandom_range(0, 2) == 0) ? sync_word : 16'($urandom);
                for (int i = 15; i >= 0; i--) qbits.push_back(rw[i]);
            end
            clk7_en       = ($urandom_range(0, 3) != 0);
            bit_strobe    = ($urandom_range(0, 1) == 1);
            bit_in        = qbits[0];
            start         = ($urandom_range(0, 29) == 0);
            len           = 14'($urandom_range(0, 4));
            fif.fifo_full = ($urandom_range(0, 7) == 0);
            byte_ack      = ($urandom_range(0, 3) == 0);
            reset         = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 149) == 0) dma_en = ~dma_en;
            else if (!dma_en && $urandom_range(0, 9) == 0) dma_en = 1'b1;
            if ($urandom_range(0, 299) == 0) wordsync_en = ~wordsync_en;
            tick();
            if (clk7_en && bit_strobe) qbits.pop_front();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paula_floppy_deserializer.md
# paula_floppy_deserializer

Upstream stage of the Paula floppy read path: turns the serial MFM bit stream from the drive interface into 16-bit words and writes them into the floppy FIFO. It also performs DSKSYNC word detection and alignment, counts the programmed DSKLEN, and raises the sync and block-done interrupt pulses. In parallel it maintains the CPU-visible DSKBYTR byte/status path. All logic advances only on `clk7_en`.

## Interface
- `WORDEQUAL_CYCLES`, default 14: number of `clk7_en` cycles WORDEQUAL stays high after a sync match (about 2 µs).
- `LEN_W`, default 14: width of the word-count input.
- `clk` in 1: bus clock.
- `reset` in 1: synchronous, active-high.
- `clk7_en` in 1: clock enable; every state change qualifies on it.
- `bit_in` in 1: MFM data bit, valid when `bit_strobe`=1.
- `bit_strobe` in 1: one new bit this enabled cycle.
- `sync_word` in 16: DSKSYNC value.
- `wordsync_en` in 1: ADKCON WORDSYNC.
- `dma_en` in 1: DSKLEN DMA-enable bit AND master DMA enable.
- `start` in 1: one-enabled-cycle pulse that arms a read transfer.
- `len` in LEN_W: number of words to transfer, sampled on `start`.
- `fifo_full` in 1: FIFO full flag.
- `fifo_wr` out 1: FIFO write strobe.
- `fifo_data` out 16: word to write.
- `syncint` out 1: one-enabled-cycle pulse on a sync match.
- `blkint` out 1: one-enabled-cycle pulse when the transfer completes.
- `overrun` out 1: sticky; set when a word is dropped because `fifo_full`=1; cleared by `start` or reset.
- `busy` out 1: high in WAIT_SYNC or XFER.
- `byte_data` out 8: DSKBYTR[7:0].
- `byte_ready` out 1: DSKBYTR[15].
- `byte_ack` in 1: DSKBYTR read; clears `byte_ready`.
- `word_equal` out 1: DSKBYTR[13].

## Operation
- **Shift register** `sr[15:0]`: on each `bit_strobe`, `sr <= {sr[14:0], bit_in}`. It runs in every state.
- **Sync match**: the new `sr` equals `sync_word` after a shift.
  - Every match sets `word_equal` for WORDEQUAL_CYCLES enabled cycles. It retriggers if another match occurs.
  - A match also pulses `syncint`.
- **Counters**:
  - `bitcnt` (4-bit) wraps 15→0.
  - `bytecnt` (3-bit) wraps 7→0.
  - When `wordsync_en`=1, a match forces both counters to 0, so the next bit starts a new word/byte.
- **Byte path**: when `bytecnt` wraps, or on a realigning match, load `byte_data <= sr[7:0]` and set `byte_ready`=1. `byte_ack` clears `byte_ready`. If `byte_ack` and a new byte arrive in the same cycle, the new byte wins and `byte_ready` stays 1.
- **FSM states**: IDLE, WAIT_SYNC, XFER.
  - **IDLE**: on `start` with `dma_en`=1 and `len`≠0, load `wcnt <= len`, clear `overrun`, reset `bitcnt`. Go to WAIT_SYNC if `wordsync_en`=1, otherwise to XFER. A `start` with `len`=0 or `dma_en`=0 is ignored: no interrupt, stay in IDLE.
  - **WAIT_SYNC**: the first match moves to XFER. The sync word itself is not written.
  - **XFER**: a word completes when `bitcnt` wraps, or on a realigning match.
    - On completion, `fifo_wr`=1 and `fifo_data=sr`, or the word is dropped and `overrun` set if `fifo_full`=1.
    - `wcnt` decrements in either case.
    - When `wcnt` reaches 0, pulse `blkint` and go to IDLE.
  - `dma_en` falling in WAIT_SYNC or XFER aborts to IDLE. No `blkint` is raised and no partial word is written.
  - `start` while `busy` is ignored.
- **Reset values**: all outputs 0, FSM in IDLE, `sr`=0, all counters 0.

## Timing
- Registered outputs. The enabled edge that shifts in the 16th bit sets `fifo_wr`/`fifo_data`. They hold until the next enabled edge, then clear, giving exactly one enabled cycle for the FIFO to capture.
- `syncint`, `blkint` and `byte_ready` rise at the same enabled edge as the causing bit.
- `blkint` coincides with the last `fifo_wr`.
- When the final word completes and a sync match occurs on the same bit: one write, one `blkint`, and one `syncint`.
- Minimum bit spacing is 2 enabled cycles. Back-to-back strobes must still be handled without loss.

## Structure
- Shared package `paula_floppy_pkg` holds:
  - the state typedef (IDLE/WAIT_SYNC/XFER);
  - the constant `DSKSYNC_DEFAULT`=16'h4489;
  - `LEN_W`.
- One natural sub-module, `paula_floppy_syncdet`, contains the shift register, the match compare, and the WORDEQUAL timer. The FSM, counters and byte path stay in the top module.

## Test plan
- `wordsync_en`=1, `sync_word`=4489, `len`=2. Stream 4489, AAAA, 5555 → `syncint` once, `fifo_wr` twice with AAAA then 5555, `blkint` with the second write, then IDLE.
- `wordsync_en`=0, `len`=1. Stream 16 bits 1234 → single write 1234. No `syncint` wait before writing.
- Sync realignment: stream 3 junk bits, then 4489, then 00FF → `byte_data`=00 then FF. `byte_ready` set twice and cleared by `byte_ack`. `word_equal` high 14 enabled cycles.
- `fifo_full`=1 during word 2 of `len`=3 → words 1 and 3 written, `overrun`=1, `blkint` still raised.
- `start` with `len`=0 → no `busy`, no interrupts. Drop `dma_en` mid-XFER → IDLE, no `blkint`, no further writes.
- Assert `reset` mid-XFER → all outputs 0 next cycle. A subsequent `start` operates normally.
